vram_write_queue: RTL and testbench
===================================

Name: vram_write_queue

Overview:
Parametrised successor to the direct-store VRAM bridge. It sits between the CPU store path and the video sink (DPI bridge or framebuffer RAM). Stores are decoded into VRAM writes, refresh commands or dropped accesses. Accepted writes are buffered in a FIFO and drained over a valid/ready interface, so that sink back-pressure stalls the core instead of losing writes.

Parameters:
DATA_W, 32, store data width in bits; multiple of 8, at least 8.
DEPTH, 8, FIFO entries; power of two, at least 2.
VRAM_BASE, 32'h8000, first byte address of the VRAM window.
VRAM_BYTES, 32'h4C000, VRAM window size in bytes; multiple of DATA_W/8.
REFRESH_ADDR, 32'h54000, byte address of the frame-refresh command register.
CNT_W, 16, width of the drop counter.
Derived (localparam): WB = DATA_W/8; OFF_W = clog2(VRAM_BYTES/WB); LVL_W = clog2(DEPTH)+1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
we  in  1  CPU store strobe
address  in  32  CPU byte address
data_in  in  DATA_W  store data
be  in  WB  byte enables
stall  out  1  queue full; the CPU must hold its store
out_valid  out  1  head entry valid
out_ready  in  1  sink accepts head entry
out_addr  out  OFF_W  word offset into VRAM
out_data  out  DATA_W  write data
out_be  out  WB  byte enables
out_refresh  out  1  head entry is a refresh command
refresh_frame  out  1  sticky: a refresh has been delivered to the sink
frame_ack  in  1  clears refresh_frame
fill_level  out  LVL_W  entries currently held
drop_count  out  CNT_W  saturating count of out-of-window stores

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empties; pointers go to 0.
  - stall=0, out_valid=0, refresh_frame=0, fill_level=0, drop_count=0.
  - out_addr, out_data, out_be and out_refresh drive 0.
- Decode applies only when we=1, evaluated on address:
  - Refresh: address == REFRESH_ADDR. Enqueue with out_refresh=1, out_addr=0, data_in and be passed through.
  - VRAM: VRAM_BASE <= address < VRAM_BASE+VRAM_BYTES. Enqueue with out_refresh=0, out_addr=(address-VRAM_BASE)>>log2(WB). The low log2(WB) address bits are ignored (no misalignment fault).
  - Refresh is checked before the VRAM window.
  - Otherwise: no enqueue. drop_count increments and saturates at all-ones. Drops occur even while stall=1.
- Push and stall:
  - stall = (fill_level == DEPTH), driven from registered state only, never from out_ready.
  - A valid store is pushed only when stall=0.
  - A store presented while stall=1 is ignored; the CPU is required to re-present it.
- Pop: a pop occurs when out_valid && out_ready. out_* show the head entry combinationally from the FIFO; out_valid = (fill_level != 0).
- Simultaneous push and pop (fill below DEPTH): fill_level is unchanged and both pointers advance.
- Full with pop: stall is still 1 that cycle and the store is not pushed. stall drops the next cycle.
- Latency: a store accepted at edge N appears at the head (out_valid=1) from N+1 when the FIFO was empty. Order is strictly preserved.
- Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- refresh_frame:
  - Set on the edge where a refresh entry pops.
  - Cleared by frame_ack=1.
  - If set and clear coincide, set wins.
- Reset mid-operation discards all queued entries; pending refresh commands are lost.
- No combinational path from we, address or data_in to any output except through registers (stall excluded from we).

Test Plan:
1. Store 0x00FF00FF to 0x8000 with be=4'hF and out_ready=1 -> one cycle later out_valid=1, out_addr=0, out_data=0x00FF00FF, out_refresh=0; fill_level returns to 0.
2. Store to 0x8007 and to 0x53FFC -> out_addr=1, then out_addr=0x12FFF (with VRAM_BYTES=0x4C000, DATA_W=32).
3. Hold out_ready=0 and issue 9 stores -> stall=1 after the 8th; the 9th is ignored; fill_level=8. Release out_ready -> 8 entries drain in order; stall=0 one cycle after the first pop.
4. Store 1 to 0x54000, then frame_ack pulse -> out_refresh=1 at the head; refresh_frame=1 the edge after the pop; 0 after the ack. Ack coinciding with a second refresh pop -> refresh_frame stays 1.
5. Stores to 0x7FFC, 0x54004 and 0x0 -> no out_valid; drop_count=3. Preload drop_count near the saturation limit -> it holds at 0xFFFF.
6. Assert rst_n low mid-drain with 5 entries queued -> out_valid=0, fill_level=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vram_write_queue.sv
// CPU store decoder feeding a FIFO of VRAM writes and refresh commands,
// drained over valid/ready so sink back-pressure stalls the core.
module vram_write_queue #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] VRAM_BASE    = 32'h8000,
  parameter logic [31:0] VRAM_BYTES   = 32'h4C000,
  parameter logic [31:0] REFRESH_ADDR = 32'h54000,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned WB          = DATA_W / 8,
  localparam int unsigned OFF_W       = $clog2(VRAM_BYTES / WB),
  localparam int unsigned LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] data_in,
  input  logic [WB-1:0]     be,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OFF_W-1:0]  out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [WB-1:0]     out_be,
  output logic              out_refresh,
  output logic              refresh_frame,
  input  logic              frame_ack,
  output logic [LVL_W-1:0]  fill_level,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned WB_LG = $clog2(WB);
  localparam logic [32:0] VRAM_END = {1'b0, VRAM_BASE} + {1'b0, VRAM_BYTES};

  logic [OFF_W-1:0]  mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [WB-1:0]     mem_be   [DEPTH];
  logic              mem_ref  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] fill;

  logic             is_refresh, in_window, accept, drop, push, pop;
  logic [OFF_W-1:0] enq_addr;

  always_comb begin
    is_refresh = (address == REFRESH_ADDR);
    in_window  = ({1'b0, address} >= {1'b0, VRAM_BASE}) && ({1'b0, address} < VRAM_END);
    enq_addr   = '0;
    if (!is_refresh) enq_addr = OFF_W'((address - VRAM_BASE) >> WB_LG);
    accept     = we && (is_refresh || in_window);
    drop       = we && !is_refresh && !in_window;
  end

  // stall depends only on the registered fill level, never on out_ready
  assign stall      = (fill == LVL_W'(DEPTH));
  assign out_valid  = (fill != '0);
  assign push       = accept && !stall;
  assign pop        = out_valid && out_ready;
  assign fill_level = fill;

  // Head is gated with out_valid so outputs read 0 when empty or in reset
  always_comb begin
    out_addr    = '0;
    out_data    = '0;
    out_be      = '0;
    out_refresh = 1'b0;
    if (out_valid) begin
      out_addr    = mem_addr[rd_ptr];
      out_data    = mem_data[rd_ptr];
      out_be      = mem_be[rd_ptr];
      out_refresh = mem_ref[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= enq_addr;
      mem_data[wr_ptr] <= data_in;
      mem_be[wr_ptr]   <= be;
      mem_ref[wr_ptr]  <= is_refresh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + LVL_W'(1);
        2'b01:   fill <= fill - LVL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_frame <= 1'b0;
    end else if (pop && mem_ref[rd_ptr]) begin
      refresh_frame <= 1'b1;
    end else if (frame_ack) begin
      refresh_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// Self-checking bench for vram_write_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_vram_write_queue;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000;
  localparam logic [31:0] BYTES = 32'h4C000;
  localparam logic [31:0] REFA  = 32'h54000;

  logic        clk, rst_n, we, out_ready, frame_ack;
  logic [31:0] address, data_in;
  logic [3:0]  be;
  logic        stall, out_valid, out_refresh, refresh_frame;
  logic [16:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [3:0]  fill_level;
  logic [15:0] drop_count;

  vram_write_queue #(.DATA_W(32), .DEPTH(DEPTH), .VRAM_BASE(BASE), .VRAM_BYTES(BYTES),
                     .REFRESH_ADDR(REFA), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .address(address), .data_in(data_in), .be(be),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_be(out_be), .out_refresh(out_refresh),
    .refresh_frame(refresh_frame), .frame_ack(frame_ack), .fill_level(fill_level),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        rf;
  } ent_t;

  ent_t mq[$];
  int   m_drop;
  bit   m_rf;
  int   checks, failures;

  task automatic idle_inputs();
    we = 1'b0; address = '0; data_in = '0; be = '0; out_ready = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    mq.delete(); m_drop = 0; m_rf = 1'b0;
    #2;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: drive inputs, predict from the decode rules, advance the model.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic rdy, input logic ack);
    ent_t e;
    bit do_push, do_pop, is_drop;
    we = w; address = a; data_in = d; be = b; out_ready = rdy; frame_ack = ack;
    do_pop = (mq.size() != 0) && rdy;
    do_push = 1'b0; is_drop = 1'b0;
    e.addr = '0; e.data = d; e.be = b; e.rf = 1'b0;
    if (w) begin
      if (a == REFA) begin
        e.rf = 1'b1; do_push = 1'b1;
      end else if (a >= BASE && (a - BASE) < BYTES) begin
        e.addr = 17'((a - BASE) / 4); do_push = 1'b1;
      end else begin
        is_drop = 1'b1;
      end
      if (mq.size() == DEPTH) do_push = 1'b0;
    end
    @(posedge clk);
    if (do_pop && mq[0].rf) m_rf = 1'b1;
    else if (ack) m_rf = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    if (is_drop && m_drop < 65535) m_drop++;
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++; if ({stall, out_valid, refresh_frame} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {stall, out_valid, refresh_frame}); end
    checks++; if (fill_level !== 4'd0) begin failures++;
      $display("FAIL reset_fill got=%0d exp=0", fill_level); end
    checks++; if (drop_count !== 16'd0) begin failures++;
      $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    checks++; if ({out_addr, out_data, out_be, out_refresh} !== '0) begin failures++;
      $display("FAIL reset_head got=%h/%h/%h/%b exp=0", out_addr, out_data, out_be, out_refresh); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 32'h8000, 32'h00FF00FF, 4'hF, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++;
      $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if ({out_addr, out_data, out_be, out_refresh} !== {17'd0, 32'h00FF00FF, 4'hF, 1'b0}) begin
      failures++; $display("FAIL basic_head got=%h/%h/%h/%b exp=0/00ff00ff/f/0",
                           out_addr, out_data, out_be, out_refresh); end
    checks++; if (fill_level !== 4'd1) begin failures++;
      $display("FAIL basic_fill1 got=%0d exp=1", fill_level); end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if ({out_valid, fill_level} !== 5'd0) begin failures++;
      $display("FAIL basic_drained got=%b/%0d exp=0/0", out_valid, fill_level); end
  endtask

  task automatic test_addr();
    do_reset();
    step(1'b1, 32'h8007, 32'hA, 4'h3, 1'b0, 1'b0);
    checks++; if (out_addr !== 17'd1) begin failures++;
      $display("FAIL addr_unaligned got=%h exp=1", out_addr); end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h53FFC, 32'hB, 4'hF, 1'b0, 1'b0);
    checks++; if (out_addr !== 17'h12FFF) begin failures++;
      $display("FAIL addr_top got=%h exp=12fff", out_addr); end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (fill_level !== 4'd0) begin failures++;
      $display("FAIL addr_drain got=%0d exp=0", fill_level); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, BASE + 32'(4 * i), 32'(i), 4'hF, 1'b0, 1'b0);
      if (i == 7) begin
        checks++; if ({stall, fill_level} !== {1'b1, 4'd8}) begin failures++;
          $display("FAIL full_stall got=%b/%0d exp=1/8", stall, fill_level); end
      end
    end
    checks++; if (fill_level !== 4'd8) begin failures++;
      $display("FAIL full_ignored got=%0d exp=8", fill_level); end
    step(1'b1, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'd1) begin failures++;
      $display("FAIL full_drop got=%0d exp=1", drop_count); end
    checks++; if (out_data !== 32'd0) begin failures++;
      $display("FAIL full_order0 got=%0d exp=0", out_data); end
    // store presented on the same edge as the first pop from full is ignored
    step(1'b1, BASE + 32'd36, 32'd99, 4'hF, 1'b1, 1'b0);
    checks++; if ({stall, fill_level} !== {1'b0, 4'd7}) begin failures++;
      $display("FAIL full_pop got=%b/%0d exp=0/7", stall, fill_level); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (out_data !== 32'(i)) begin failures++;
        $display("FAIL full_order got=%0d exp=%0d", out_data, i); end
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if ({out_valid, fill_level} !== 5'd0) begin failures++;
      $display("FAIL full_empty got=%b/%0d exp=0/0", out_valid, fill_level); end
  endtask

  task automatic test_refresh();
    do_reset();
    step(1'b1, REFA, 32'd1, 4'hF, 1'b0, 1'b0);
    checks++; if ({out_refresh, out_addr, out_data} !== {1'b1, 17'd0, 32'd1}) begin failures++;
      $display("FAIL ref_head got=%b/%h/%h exp=1/0/1", out_refresh, out_addr, out_data); end
    checks++; if (refresh_frame !== 1'b0) begin failures++;
      $display("FAIL ref_early got=%b exp=0", refresh_frame); end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (refresh_frame !== 1'b1) begin failures++;
      $display("FAIL ref_set got=%b exp=1", refresh_frame); end
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (refresh_frame !== 1'b0) begin failures++;
      $display("FAIL ref_ack got=%b exp=0", refresh_frame); end
    step(1'b1, REFA, 32'd2, 4'hF, 1'b0, 1'b0);
    step(1'b1, REFA, 32'd3, 4'hF, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    checks++; if (refresh_frame !== 1'b1) begin failures++;
      $display("FAIL ref_set_wins got=%b exp=1", refresh_frame); end
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++; if (refresh_frame !== 1'b0) begin failures++;
      $display("FAIL ref_ack2 got=%b exp=0", refresh_frame); end
  endtask

  task automatic test_drop();
    do_reset();
    step(1'b1, 32'h7FFC, 32'h1, 4'hF, 1'b1, 1'b0);
    step(1'b1, 32'h54004, 32'h2, 4'hF, 1'b1, 1'b0);
    step(1'b1, 32'h0, 32'h3, 4'hF, 1'b1, 1'b0);
    checks++; if ({out_valid, fill_level} !== 5'd0) begin failures++;
      $display("FAIL drop_noenq got=%b/%0d exp=0/0", out_valid, fill_level); end
    checks++; if (drop_count !== 16'd3) begin failures++;
      $display("FAIL drop_count got=%0d exp=3", drop_count); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int unsigned r;
    logic rdy;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:          a = REFA;
        2, 3, 4, 5, 6: a = BASE + $urandom_range(0, BYTES - 1);
        7:             a = BASE - 32'd1 - $urandom_range(0, 63);
        8:             a = REFA + 32'd4 + $urandom_range(0, 63);
        default:       a = $urandom;
      endcase
      rdy = ((i / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, a, $urandom, 4'($urandom), rdy, $urandom_range(0, 4) == 0);
      checks++; if ({stall, out_valid, fill_level} !== {mq.size() == DEPTH, mq.size() != 0, 4'(mq.size())}) begin
        failures++; $display("FAIL rnd_level cyc=%0d got=%b/%b/%0d exp=%0d", i, stall, out_valid, fill_level, mq.size()); end
      checks++; if (drop_count !== 16'(m_drop)) begin failures++;
        $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", i, drop_count, m_drop); end
      checks++; if (refresh_frame !== m_rf) begin failures++;
        $display("FAIL rnd_rframe cyc=%0d got=%b exp=%b", i, refresh_frame, m_rf); end
      if (mq.size() != 0) begin
        checks++; if ({out_addr, out_data, out_be, out_refresh} !== {mq[0].addr, mq[0].data, mq[0].be, mq[0].rf}) begin
          failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", i, out_addr, out_data,
                               out_be, out_refresh, mq[0].addr, mq[0].data, mq[0].be, mq[0].rf); end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65535; i++) step(1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'hFFFF) begin failures++;
      $display("FAIL sat_reach got=%h exp=ffff", drop_count); end
    step(1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0);
    step(1'b1, 32'h4, 32'h0, 4'hF, 1'b0, 1'b0);
    checks++; if (drop_count !== 16'hFFFF) begin failures++;
      $display("FAIL sat_hold got=%h exp=ffff", drop_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, BASE + 32'(4 * i), 32'(i + 16), 4'hF, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++; if (fill_level !== 4'd5) begin failures++;
      $display("FAIL mid_pre got=%0d exp=5", fill_level); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, stall, fill_level} !== 6'd0) begin failures++;
      $display("FAIL mid_async got=%b/%b/%0d exp=0/0/0", out_valid, stall, fill_level); end
    checks++; if ({out_addr, out_data, out_be, out_refresh} !== '0) begin failures++;
      $display("FAIL mid_head got=%h/%h exp=0", out_addr, out_data); end
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL mid_after got=%b exp=0", out_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    mq.delete(); m_drop = 0; m_rf = 1'b0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_addr();
    test_full();
    test_refresh();
    test_drop();
    test_random();
    test_mid_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
